// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between a PS/2 command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_err,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_err,
    output busy
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, device ack.
// Define PS2_TX_ACK_CHECK_EN to treat a high ack bit as NACK and time out WAITIDLE too.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int unsigned IDX_W   = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_RELEASE  = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_ACK      = 3'd5;
  localparam logic [2:0] S_WAITIDLE = 3'd6;

  logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic             flt_q, flt_d;
  logic [FLT_W-1:0] fcnt_q, fcnt_d;
  logic             fall_q, fall_d;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_c, timed_c, tmo_c;

  // Pin synchronizers; idle lines float high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_i;
      data_s2_q <= data_s1_q;
    end
  end

  // Clock level changes only after FILTER_LEN consecutive differing samples
  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (clk_s2_q != flt_q) begin
      if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
        flt_d  = clk_s2_q;
        fall_d = flt_q;
      end else begin
        fcnt_d = fcnt_q + FLT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_q  <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      flt_q  <= flt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
    end
  end

  // Held off during the completion pulse so a waiting byte is taken the cycle after
  assign ready_c = (state_q == S_IDLE) && !reset && !done_q && !err_q;

`ifdef PS2_TX_ACK_CHECK_EN
  assign timed_c = (state_q == S_SHIFT) || (state_q == S_STOP) ||
                   (state_q == S_ACK)   || (state_q == S_WAITIDLE);
`else
  assign timed_c = (state_q == S_SHIFT) || (state_q == S_STOP) || (state_q == S_ACK);
`endif
  assign tmo_c = timed_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (timed_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx.tx_valid && ready_c) begin
          shreg_d  = {~^tx.tx_data, tx.tx_data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall_q) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[8:1]};
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(8)) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (fall_q) begin
          data_oe_d = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (fall_q) begin
`ifdef PS2_TX_ACK_CHECK_EN
          if (data_s2_q) begin
            err_d     = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAITIDLE;
          end
`else
          state_d = S_WAITIDLE;
`endif
        end
      end
      S_WAITIDLE: begin
        if (flt_q && data_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Timeout wins over any frame progress in the same cycle
    if (tmo_c) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx.tx_ready  = ready_c;
  assign tx.tx_done   = done_q;
  assign tx.tx_err    = err_q;
  assign tx.busy      = (state_q != S_IDLE);
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model (clock scaled down).
module tb_ps2_host_tx;
  localparam int unsigned INH  = 100;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned FLT  = 2;
  localparam int unsigned HALF = 20;

  typedef struct {
    logic       is_err;
    logic       chk;
    logic [9:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic dev_active = 1'b0;
  logic [9:0] cap = '0;
  logic start_ok = 1'b0;
  int low_len = 0;
  int dev_falls = 0;
  int dev_mode = 0;
  int n_results = 0;
  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  exp_t e;

  ps2_host_tx_if tx_if ();

  assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx(tx_if),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Device: mode 0 acks, mode 1 leaves data high at the ack, mode 2 never clocks
  initial begin : device
    int n;
    forever begin
      @(negedge clk);
      if (ps2_clk_oe === 1'b1) begin
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 100000) begin
          n++;
          @(negedge clk);
        end
        low_len  = n;
        start_ok = ps2_data_oe;
        if (dev_mode != 2) begin
          dev_active = 1'b1;
          for (int k = 1; k <= 11; k++) begin
            repeat (HALF) @(negedge clk);
            if (k == 11 && dev_mode == 0) dev_data = 1'b0;
            dev_clk   = 1'b0;
            dev_falls = k;
            repeat (HALF) @(negedge clk);
            if (k <= 10) cap = {ps2_data_i, cap[9:1]};
            dev_clk = 1'b1;
          end
          repeat (HALF) @(negedge clk);
          dev_data   = 1'b1;
          dev_active = 1'b0;
        end
      end
    end
  end

  // Monitor: every done/err pulse consumes one expected result
  always @(negedge clk) begin
    if (tx_if.tx_done === 1'b1 || tx_if.tx_err === 1'b1) begin
      chk("done_err_exclusive", 32'(tx_if.tx_done & tx_if.tx_err), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b, no result expected",
                 tx_if.tx_done, tx_if.tx_err);
      end else begin
        e = exp_q.pop_front();
        chk("result_is_err", 32'(tx_if.tx_err), 32'(e.is_err));
        chk("busy_low_on_pulse", 32'(tx_if.busy), 32'd0);
        chk("ready_low_on_pulse", 32'(tx_if.tx_ready), 32'd0);
        if (e.chk) begin
          chk("frame_bits", 32'(cap), 32'(e.bits));
          chk("clk_low_cycles", 32'(low_len), 32'(INH + 1));
          chk("start_bit_before_release", 32'(start_ok), 32'd1);
        end
      end
      n_results++;
    end
  end

  task automatic send(input logic [7:0] b, input logic push, input logic is_err,
                      input logic chk_bits, input logic [9:0] bits);
    exp_t x;
    int c;
    c = 0;
    while (tx_if.tx_ready !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("ready_before_send", 32'(tx_if.tx_ready), 32'd1);
    if (push) begin
      x.is_err = is_err;
      x.chk    = chk_bits;
      x.bits   = bits;
      exp_q.push_back(x);
    end
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    chk("clk_oe_after_handshake", 32'(ps2_clk_oe), 32'd1);
  endtask

  task automatic wait_results(input int target);
    int c;
    c = 0;
    while (n_results < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("result_arrived", 32'(n_results >= target), 32'd1);
  endtask

  task automatic wait_dev_idle();
    int c;
    c = 0;
    while (dev_active && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("device_idle", 32'(dev_active), 32'd0);
  endtask

  initial begin : main
    int c;
    logic seen;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_ready", 32'(tx_if.tx_ready), 32'd0);
    chk("rst_done", 32'(tx_if.tx_done), 32'd0);
    chk("rst_err", 32'(tx_if.tx_err), 32'd0);
    chk("rst_busy", 32'(tx_if.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(tx_if.tx_ready), 32'd1);

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
    dev_mode = 0;
    send(8'hED, 1'b1, 1'b0, 1'b1, 10'h3ED);
    wait_results(1);

    // 0xF4: bits 0,0,1,0,1,1,1,1 parity 0 stop 1
    send(8'hF4, 1'b1, 1'b0, 1'b1, 10'h2F4);
    wait_results(2);

    // Silent device: error exactly TMO cycles after clock release
    dev_mode = 2;
    send(8'hF4, 1'b1, 1'b1, 1'b0, 10'h000);
    c = 0;
    while (ps2_clk_oe === 1'b1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    while (tx_if.tx_err !== 1'b1 && c < int'(TMO) + 10) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_cycles", 32'(c), 32'(TMO));
    chk("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    chk("ready_after_timeout", 32'(tx_if.tx_ready), 32'd1);
    wait_results(3);

    // NACK: error only when the ack check is built in
    dev_mode = 1;
`ifdef PS2_TX_ACK_CHECK_EN
    send(8'hF4, 1'b1, 1'b1, 1'b1, 10'h2F4);
`else
    send(8'hF4, 1'b1, 1'b0, 1'b1, 10'h2F4);
`endif
    wait_results(4);
    wait_dev_idle();

    // Reset during data bit 4: lines released, no pulse
    dev_mode  = 0;
    dev_falls = 0;
    send(8'hED, 1'b0, 1'b0, 1'b0, 10'h000);
    c = 0;
    while (dev_falls < 5 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("reached_bit4", 32'(dev_falls >= 5), 32'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("midrst_busy", 32'(tx_if.busy), 32'd0);
    chk("midrst_ready", 32'(tx_if.tx_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", 32'(tx_if.tx_ready), 32'd1);
    wait_dev_idle();
    chk("no_pulse_on_reset", 32'(n_results), 32'd4);
    send(8'hED, 1'b1, 1'b0, 1'b1, 10'h3ED);
    wait_results(5);

    // Back-to-back: 0x02 held on tx_valid through an 0xED frame
    send(8'hED, 1'b1, 1'b0, 1'b1, 10'h3ED);
    tx_if.tx_data  = 8'h02;
    tx_if.tx_valid = 1'b1;
    exp_q.push_back('{is_err: 1'b0, chk: 1'b1, bits: 10'h202});
    seen = 1'b0;
    c = 0;
    while (tx_if.tx_done !== 1'b1 && c < 5000) begin
      if (tx_if.tx_ready === 1'b1) seen = 1'b1;
      @(negedge clk);
      c++;
    end
    chk("ready_low_during_frame", 32'(seen), 32'd0);
    chk("first_done_seen", 32'(tx_if.tx_done), 32'd1);
    @(negedge clk);
    chk("ready_after_done", 32'(tx_if.tx_ready), 32'd1);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    chk("second_byte_accepted", 32'(ps2_clk_oe), 32'd1);
    wait_results(7);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
